sap1_controller_sequencer: RTL and testbench
============================================

# sap1_controller_sequencer

Controller-sequencer for the SAP-1 datapath: a six-state ring counter plus an instruction decoder that drives the 12-bit control word steering the PC, MAR, RAM, IR, accumulator, adder/subtracter, B register and output register. It also raises HLT, and it adds a single-instruction step mode for bench and board debugging. It sits beside the instruction register, takes the IR's upper nibble, and replaces the hard-wired control logic inside SAP_1.

## Interface
Parameters:
- IDLE_WORD, 12'h3E3, control word with every signal inactive.

Ports:
- Clk  input  1  system clock; sequencer state advances on the falling edge.
- Clr  input  1  asynchronous, active-low reset.
- Opcode  input  4  IR[7:4], held stable by the IR from T4 through T6.
- Mode  input  1  0 = run continuously, 1 = single-instruction step.
- Step  input  1  single-cycle, synchronous pulse; honoured only in WAIT.
- CON  output  12  control word {Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo}.
- TState  output  6  one-hot ring state; bit0 = T1 … bit5 = T6; 0 in WAIT/HALT.
- HLT  output  1  high while halted.
- InstrDone  output  1  high for the whole T6 state.

## Operation
- States: T1–T6, WAIT, HALT. State register updates on the negedge of Clk, so CON is stable at every datapath posedge.
- CON is decoded combinationally from the state and Opcode.
- Fetch words, independent of Opcode:
  - T1 = 12'h5E3 (Ep, Lm).
  - T2 = 12'hBE3 (Cp).
  - T3 = 12'h263 (CE, Li).
- Execute words by opcode:
  - LDA 4'h0: T4 = 1A3 (Lm, Ei), T5 = 2C3 (CE, La), T6 = 3E3.
  - ADD 4'h1: T4 = 1A3, T5 = 2E1 (CE, Lb), T6 = 3C7 (La, Eu).
  - SUB 4'h2: T4 = 1A3, T5 = 2E1, T6 = 3CF (La, Su, Eu).
  - OUT 4'hE: T4 = 3F2 (Ea, Lo), T5 = 3E3, T6 = 3E3.
  - HLT 4'hF: see below.
  - Any other opcode: NOP, so T4–T6 = 3E3.
- Transitions:
  - T1→T2→T3→T4→T5→T6.
  - T6→T1 if Mode=0; T6→WAIT if Mode=1.
  - Mode is sampled only at the T6 exit edge; a change mid-instruction has no effect on the current instruction.
  - WAIT→T1 on a negedge with Step=1 or Mode=0; otherwise stay in WAIT.
  - T4 with Opcode=4'hF → HALT at the next negedge.
  - HALT is absorbing; only Clr leaves it.
- HLT output: 1 from the T4 cycle decoding 4'hF (combinational) and through all of HALT. CON = IDLE_WORD in that T4 and in HALT.
- WAIT: CON = IDLE_WORD, TState = 0, HLT = 0.

## Timing
- Clr low (asynchronous, any time, including mid-instruction): state → T1 immediately.
  - While Clr is low: CON forced to IDLE_WORD, TState = 6'b000001, HLT = 0, InstrDone = 0.
- After Clr rises:
  - CON = 12'h5E3 at once.
  - First advance at the first negedge following release.
- Run mode: one instruction = exactly 6 Clk periods. T1 of the next instruction begins on the negedge ending T6, with no bubble.
- Step mode: 6 periods in T1–T6, then ≥1 period in WAIT. A Step high at a WAIT negedge yields T1 half a period later.
- Step outside WAIT is ignored; it is not queued.
- Cp is high in T2 only, so the PC increments exactly once per instruction, including in step mode.
- HALT entry: state reaches HALT at the T4→ negedge; TState = 0 thereafter.

## Test plan
- Reset: hold Clr=0 for 7 ns with a 10 ns Clk, then release -> CON = 3E3 and TState = 000001 during reset; CON = 5E3 after release; T2 (CON = BE3) after the first negedge.
- LDA then ADD, Mode=0 -> CON sequence 5E3, BE3, 263, 1A3, 2C3, 3E3, 5E3, BE3, 263, 1A3, 2E1, 3C7; InstrDone high in each T6.
- SUB and OUT -> SUB T6 = 3CF; OUT T4 = 3F2, T5/T6 = 3E3; undefined opcode 4'h5 gives 3E3 in T4–T6.
- HLT (4'hF) -> HLT rises in T4 with CON = 3E3. With Clk running, HLT stays 1, TState = 0 and CON = 3E3 over 20 further cycles; Clr pulse returns to T1 with HLT = 0.
- Step mode: Mode=1 -> after T6, WAIT with CON = 3E3 holds for 10 cycles. A 1-cycle Step gives exactly one T1–T6 pass, then WAIT again. Step pulses in T3 are ignored. Mode=0 while in WAIT resumes at T1.
- Reset mid-instruction: Clr low during ADD T5 -> CON = 3E3 and TState = 000001 within the same cycle, no Lb/La pulse afterwards; the restart fetch begins with 5E3.

Source files
------------

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: six-state ring counter (T1-T6) plus WAIT/HALT,
// decoding the IR opcode nibble into the 12-bit datapath control word.
module sap1_controller_sequencer #(
    parameter logic [11:0] IDLE_WORD = 12'h3E3
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [3:0]  Opcode,
    input  logic        Mode,
    input  logic        Step,
    output logic [11:0] CON,
    output logic [5:0]  TState,
    output logic        HLT,
    output logic        InstrDone
);

    typedef enum logic [2:0] {
        S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_WAIT, S_HALT
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t state;

    // Falling-edge update keeps CON settled across every datapath rising edge.
    // NOTE: state registers use non-blocking assignment so every read in this block sees the pre-edge value.
    always_ff @(negedge Clk or negedge Clr) begin
        if (!Clr) begin
            state <= S_T1;
        end else begin
            unique case (state)
                S_T1:    state <= S_T2;
                S_T2:    state <= S_T3;
                S_T3:    state <= S_T4;
                S_T4:    state <= (Opcode == OP_HLT) ? S_HALT : S_T5;
                S_T5:    state <= S_T6;
                S_T6:    state <= Mode ? S_WAIT : S_T1;
                S_WAIT:  state <= (Step || !Mode) ? S_T1 : S_WAIT;
                S_HALT:  state <= S_HALT;
                default: state <= S_T1;
            endcase
        end
    end

    logic [11:0] con_dec;

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        con_dec = IDLE_WORD;
        unique case (state)
            S_T1: con_dec = 12'h5E3;
            S_T2: con_dec = 12'hBE3;
            S_T3: con_dec = 12'h263;
            S_T4: begin
                if (Opcode == OP_LDA || Opcode == OP_ADD || Opcode == OP_SUB)
                    con_dec = 12'h1A3;
                else if (Opcode == OP_OUT)
                    con_dec = 12'h3F2;
            end
            S_T5: begin
                if (Opcode == OP_LDA)
                    con_dec = 12'h2C3;
                else if (Opcode == OP_ADD || Opcode == OP_SUB)
                    con_dec = 12'h2E1;
            end
            S_T6: begin
                if (Opcode == OP_ADD)
                    con_dec = 12'h3C7;
                else if (Opcode == OP_SUB)
                    con_dec = 12'h3CF;
            end
            default: con_dec = IDLE_WORD;
        endcase
    end

    // Clr low parks the ring at T1 but must not let the fetch word reach the datapath.
    always_comb begin
        CON       = Clr ? con_dec : IDLE_WORD;
        TState    = 6'b000000;
        HLT       = 1'b0;
        InstrDone = 1'b0;
        unique case (state)
            S_T1:    TState = 6'b000001;
            S_T2:    TState = 6'b000010;
            S_T3:    TState = 6'b000100;
            S_T4:    TState = 6'b001000;
            S_T5:    TState = 6'b010000;
            S_T6:    TState = 6'b100000;
            default: TState = 6'b000000;
        endcase
        if (Clr) begin
            HLT       = (state == S_HALT) || (state == S_T4 && Opcode == OP_HLT);
            InstrDone = (state == S_T6);
        end
    end

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Self-checking bench: randomized opcode/mode/step stimulus compared every
// cycle against a phase-number model of the SAP-1 instruction timing.
module tb_sap1_controller_sequencer;

    logic        Clk;
    logic        Clr;
    logic [3:0]  Opcode;
    logic        Mode;
    logic        Step;
    logic [11:0] CON;
    logic [5:0]  TState;
    logic        HLT;
    logic        InstrDone;

    int total = 0;
    int bad   = 0;

    // Model phase: 1..6 = T1..T6, 0 = waiting for a step, 7 = halted.
    int m_phase = 1;

    sap1_controller_sequencer dut (
        .Clk       (Clk),
        .Clr       (Clr),
        .Opcode    (Opcode),
        .Mode      (Mode),
        .Step      (Step),
        .CON       (CON),
        .TState    (TState),
        .HLT       (HLT),
        .InstrDone (InstrDone)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [11:0] exp_con(input int phase, input logic [3:0] op);
        logic [11:0] w;
        w = 12'h3E3;
        if (phase == 1) w = 12'h5E3;
        else if (phase == 2) w = 12'hBE3;
        else if (phase == 3) w = 12'h263;
        else if (phase == 4) begin
            if (op == 4'h0 || op == 4'h1 || op == 4'h2) w = 12'h1A3;
            else if (op == 4'hE) w = 12'h3F2;
        end else if (phase == 5) begin
            if (op == 4'h0) w = 12'h2C3;
            else if (op == 4'h1 || op == 4'h2) w = 12'h2E1;
        end else if (phase == 6) begin
            if (op == 4'h1) w = 12'h3C7;
            else if (op == 4'h2) w = 12'h3CF;
        end
        return w;
    endfunction

    function automatic logic [5:0] exp_tstate(input int phase);
        logic [5:0] t;
        t = 6'b000000;
        if (phase >= 1 && phase <= 6) t = 6'(1 << (phase - 1));
        return t;
    endfunction

    function automatic int next_phase(input int phase, input logic [3:0] op,
                                      input logic mode, input logic step);
        int n;
        if (phase == 7) n = 7;
        else if (phase == 0) n = (step || !mode) ? 1 : 0;
        else if (phase == 4 && op == 4'hF) n = 7;
        else if (phase == 6) n = mode ? 0 : 1;
        else n = phase + 1;
        return n;
    endfunction

    // One clock period: drive after the rising edge, compare, then let the falling edge advance.
    task automatic run_cycle(input logic [3:0] op, input logic mode, input logic step, input string tag);
        logic [11:0] want_con;
        logic [5:0]  want_t;
        logic        want_h;
        logic        want_d;
        @(posedge Clk);
        #1;
        Opcode = op;
        Mode   = mode;
        Step   = step;
        #1;
        want_con = exp_con(m_phase, op);
        want_t   = exp_tstate(m_phase);
        want_h   = (m_phase == 7) || (m_phase == 4 && op == 4'hF);
        want_d   = (m_phase == 6);
        total++;
        if (CON !== want_con) begin
            bad++;
            $display("FAIL %s con phase=%0d op=%h got=%h want=%h", tag, m_phase, op, CON, want_con);
        end
        total++;
        if (TState !== want_t) begin
            bad++;
            $display("FAIL %s tstate phase=%0d got=%b want=%b", tag, m_phase, TState, want_t);
        end
        total++;
        if (HLT !== want_h) begin
            bad++;
            $display("FAIL %s hlt phase=%0d got=%b want=%b", tag, m_phase, HLT, want_h);
        end
        total++;
        if (InstrDone !== want_d) begin
            bad++;
            $display("FAIL %s instr_done phase=%0d got=%b want=%b", tag, m_phase, InstrDone, want_d);
        end
        @(negedge Clk);
        m_phase = next_phase(m_phase, op, mode, step);
    endtask

    // Clr pulse after the rising edge, released before the next falling edge.
    task automatic pulse_clr(input string tag);
        logic [11:0] want_con;
        @(posedge Clk);
        #1;
        want_con = exp_con(m_phase, Opcode);
        total++;
        if (CON !== want_con) begin
            bad++;
            $display("FAIL %s pre_clr con got=%h want=%h", tag, CON, want_con);
        end
        Clr = 1'b0;
        #1;
        total++;
        if (CON !== 12'h3E3 || TState !== 6'b000001 || HLT !== 1'b0 || InstrDone !== 1'b0) begin
            bad++;
            $display("FAIL %s in_clr got con=%h t=%b h=%b d=%b want con=3e3 t=000001 h=0 d=0",
                     tag, CON, TState, HLT, InstrDone);
        end
        #1;
        Clr = 1'b1;
        #1;
        total++;
        if (CON !== 12'h5E3 || TState !== 6'b000001 || HLT !== 1'b0) begin
            bad++;
            $display("FAIL %s post_clr got con=%h t=%b h=%b want con=5e3 t=000001 h=0",
                     tag, CON, TState, HLT);
        end
        m_phase = 1;
        @(negedge Clk);
        m_phase = next_phase(m_phase, Opcode, Mode, Step);
    endtask

    // Run filler cycles (run mode, NOP) until the model sits at T1; bounded.
    task automatic sync_to_t1(input string tag);
        int n;
        n = 0;
        while (m_phase != 1 && n < 20) begin
            run_cycle(4'h5, 1'b0, 1'b0, tag);
            n++;
        end
        total++;
        if (m_phase != 1) begin
            bad++;
            $display("FAIL %s sync timeout got phase=%0d want=1", tag, m_phase);
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic mode, input string tag);
        for (int i = 0; i < 6; i++) run_cycle(op, mode, 1'b0, tag);
    endtask

    task automatic test_reset;
        Clr = 1'b0;
        Opcode = 4'h0;
        Mode = 1'b0;
        Step = 1'b0;
        #3;
        total++;
        if (CON !== 12'h3E3 || TState !== 6'b000001) begin
            bad++;
            $display("FAIL reset_hold got con=%h t=%b want con=3e3 t=000001", CON, TState);
        end
        #3;
        total++;
        if (CON !== 12'h3E3 || TState !== 6'b000001 || HLT !== 1'b0 || InstrDone !== 1'b0) begin
            bad++;
            $display("FAIL reset_edge got con=%h t=%b h=%b d=%b want con=3e3 t=000001 h=0 d=0",
                     CON, TState, HLT, InstrDone);
        end
        #1;
        Clr = 1'b1;
        #1;
        total++;
        if (CON !== 12'h5E3) begin
            bad++;
            $display("FAIL reset_release got con=%h want=5e3", CON);
        end
        m_phase = 1;
        @(negedge Clk);
        m_phase = next_phase(m_phase, Opcode, Mode, Step);
        run_cycle(4'h0, 1'b0, 1'b0, "reset_t2");
    endtask

    task automatic test_lda_add;
        sync_to_t1("lda_add_sync");
        run_instr(4'h0, 1'b0, "lda");
        run_instr(4'h1, 1'b0, "add");
    endtask

    task automatic test_sub_out_nop;
        logic [3:0] ops [3];
        ops[0] = 4'h2;
        ops[1] = 4'hE;
        ops[2] = 4'h5;
        for (int i = 0; i < 9; i++)
            run_instr(ops[$urandom_range(0, 2)], 1'b0, "sub_out_nop");
    endtask

    task automatic test_halt;
        sync_to_t1("halt_sync");
        for (int i = 0; i < 4; i++) run_cycle(4'hF, 1'b0, 1'b0, "halt_entry");
        for (int i = 0; i < 20; i++)
            run_cycle(4'(($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15))),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "halted");
        pulse_clr("halt_clr");
        for (int i = 0; i < 5; i++) run_cycle(4'h0, 1'b0, 1'b0, "after_halt");
    endtask

    task automatic test_step_mode;
        logic m;
        sync_to_t1("step_sync");
        // Mode wiggles mid-instruction; only its value at the T6 exit matters.
        for (int i = 0; i < 5; i++) run_cycle(4'h1, 1'($urandom_range(0, 1)), 1'b0, "step_mid");
        run_cycle(4'h1, 1'b1, 1'b0, "step_t6");
        for (int i = 0; i < 10; i++) run_cycle(4'h1, 1'b1, 1'b0, "wait_hold");
        run_cycle(4'h2, 1'b1, 1'b1, "step_pulse");
        for (int i = 0; i < 6; i++)
            run_cycle(4'h2, 1'b1, (m_phase == 3) ? 1'b1 : 1'b0, "step_pass");
        for (int i = 0; i < 3; i++) run_cycle(4'h2, 1'b1, 1'b0, "wait_again");
        total++;
        if (m_phase != 0) begin
            bad++;
            $display("FAIL step_single_pass got phase=%0d want=0", m_phase);
        end
        for (int k = 0; k < 3; k++) begin
            m = 1'b1;
            run_cycle(4'hE, m, 1'b1, "step_more");
            for (int i = 0; i < 6 + int'($urandom_range(1, 4)); i++)
                run_cycle(4'hE, m, 1'($urandom_range(0, 1) & (m_phase != 0)), "step_more");
        end
        run_cycle(4'h0, 1'b0, 1'b0, "wait_resume");
        for (int i = 0; i < 6; i++) run_cycle(4'h0, 1'b0, 1'b0, "resumed");
    endtask

    task automatic test_reset_mid;
        sync_to_t1("mid_sync");
        for (int i = 0; i < 4; i++) run_cycle(4'h1, 1'b0, 1'b0, "mid_add");
        pulse_clr("mid_clr");
        for (int i = 0; i < 8; i++) run_cycle(4'h1, 1'b0, 1'b0, "mid_restart");
    endtask

    task automatic test_random;
        logic [3:0] op;
        logic [3:0] pool [7];
        int halted;
        pool[0] = 4'h0; pool[1] = 4'h1; pool[2] = 4'h2; pool[3] = 4'hE;
        pool[4] = 4'h5; pool[5] = 4'h3; pool[6] = 4'hF;
        op = 4'h0;
        halted = 0;
        for (int i = 0; i < 400; i++) begin
            if (m_phase == 7) begin
                halted++;
                if (halted > 3) begin
                    pulse_clr("rand_clr");
                    halted = 0;
                    continue;
                end
            end
            // Opcode only changes outside T4-T6, as the IR would hold it.
            if (m_phase <= 3 || m_phase == 0) begin
                if ($urandom_range(0, 15) == 0) op = 4'hF;
                else op = pool[$urandom_range(0, 5)];
            end
            run_cycle(op, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0), "random");
        end
    endtask

    initial begin
        test_reset();
        test_lda_add();
        test_sub_out_nop();
        test_halt();
        test_step_mode();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
